// File: rtl/master_tx_ltssm.sv
// TX-side LTSSM sequencer: drives the ordered-set stream each substate needs and pulses txFinish.
// Optional EIEOS insertion for Gen3 training is compiled in with EIEOS_INSERT_EN.
module master_tx_ltssm #(
  parameter int MAXLANES   = 16,
  parameter int POLL_MIN   = 1024,
  parameter int POST_COUNT = 16,
  parameter int CNT_W      = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          substate,
  input  logic [2:0]          trainToGen,
  input  logic                rxFinish,
  input  logic [7:0]          linkNumber,
  input  logic                osReady,
  output logic                osValid,
  output logic [2:0]          osType,
  output logic [7:0]          osLinkNum,
  output logic [MAXLANES-1:0] osLaneMask,
  output logic                txElectricalIdle,
  output logic                dataEnable,
  output logic                txFinish,
  output logic [CNT_W-1:0]    sentCount
);

  localparam logic [2:0] OS_NONE  = 3'd0;
  localparam logic [2:0] OS_TS1   = 3'd1;
  localparam logic [2:0] OS_TS2   = 3'd2;
  localparam logic [2:0] OS_IDLE  = 3'd3;
  localparam logic [2:0] OS_EIOS  = 3'd4;
  localparam logic [2:0] OS_EIEOS = 3'd5;

  localparam logic [4:0] SUB_L0       = 5'd10;
  localparam logic [4:0] SUB_RCVRLOCK = 5'd11;
  localparam logic [4:0] SUB_RECSPEED = 5'd13;

  localparam int PW = (POST_COUNT > 0) ? $clog2(POST_COUNT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_POST, S_DONE} state_e;

  function automatic logic [2:0] sub_type(input logic [4:0] s);
    case (s)
      5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd11,
      5'd14, 5'd15, 5'd16, 5'd17:   sub_type = OS_TS1;
      5'd3, 5'd8, 5'd12:            sub_type = OS_TS2;
      5'd9, 5'd18:                  sub_type = OS_IDLE;
      5'd13:                        sub_type = OS_EIOS;
      default:                      sub_type = OS_NONE;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sub_min(input logic [4:0] s);
    sub_min = (s == 5'd2) ? CNT_W'(POLL_MIN) : CNT_W'(1);
  endfunction

  function automatic logic sub_post(input logic [4:0] s);
    sub_post = (POST_COUNT > 0) &&
               (s == 5'd3 || s == 5'd8 || s == 5'd12 || s == 5'd9 || s == 5'd18);
  endfunction

  function automatic logic sub_pad(input logic [4:0] s);
    sub_pad = (s == 5'd2 || s == 5'd3 || s == 5'd4);
  endfunction

  state_e              state_q, state_d;
  logic [4:0]          last_q, last_d, act_q, act_d;
  logic                rx_q, rx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]       post_q, post_d;
  logic                valid_q, valid_d;
  logic [2:0]          type_q, type_d;
  logic [7:0]          link_q, link_d;
  logic [MAXLANES-1:0] mask_q, mask_d;
  logic                ei_q, ei_d, de_q, de_d, fin_q, fin_d;
  logic                acc, cnt_acc, rx_nx;

`ifdef EIEOS_INSERT_EN
  logic       gen3;
  logic [4:0] ts_q, ts_d;
  assign gen3 = (trainToGen == 3'd3);
`else
  logic unused_gen;
  assign unused_gen = ^trainToGen;
`endif

  assign acc     = valid_q && osReady;
  // EIEOS acceptances never advance the substate's ordered-set count
  assign cnt_acc = acc && (type_q != OS_EIEOS);
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign rx_nx   = rx_q || rxFinish;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    act_d   = act_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    post_d  = post_q;
    valid_d = valid_q;
    type_d  = type_q;
    link_d  = link_q;
    ei_d    = ei_q;
    de_d    = de_q;
    fin_d   = 1'b0;
`ifdef EIEOS_INSERT_EN
    ts_d    = ts_q;
`endif
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (substate != last_q) begin
          state_d = S_SEND;
          act_d   = substate;
          cnt_d   = '0;
          rx_d    = 1'b0;
          post_d  = '0;
          type_d  = sub_type(substate);
          valid_d = (sub_type(substate) != OS_NONE);
          link_d  = sub_pad(substate) ? 8'hF7 : linkNumber;
          ei_d    = (sub_type(substate) == OS_NONE) && (substate != SUB_L0);
          de_d    = (substate == SUB_L0);
`ifdef EIEOS_INSERT_EN
          ts_d    = '0;
          if (gen3 && substate == SUB_RCVRLOCK) type_d = OS_EIEOS;
`endif
        end
      end
      S_SEND, S_POST: begin
        if (cnt_acc)  cnt_d = cnt_inc;
        if (rxFinish) rx_d  = 1'b1;
`ifdef EIEOS_INSERT_EN
        if (acc) begin
          if (type_q == OS_EIEOS) begin
            type_d = sub_type(act_q);
          end else if (gen3 && (type_q == OS_TS1 || type_q == OS_TS2)) begin
            if (ts_q == 5'd31) begin
              ts_d   = '0;
              type_d = OS_EIEOS;
            end else begin
              ts_d = ts_q + 5'd1;
            end
          end
        end
`endif
        if (substate != act_q) begin
          // abort: drop the substate silently, lastState untouched
          state_d = S_IDLE;
          valid_d = 1'b0;
          de_d    = 1'b0;
        end else if (state_q == S_POST) begin
          if (cnt_acc) begin
            post_d = post_q + PW'(1);
            if (post_q == PW'(POST_COUNT - 1)) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              fin_d   = 1'b1;
            end
          end
        end else if (act_q == SUB_L0) begin
          state_d = S_SEND;
        end else if (sub_type(act_q) == OS_NONE) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          fin_d   = 1'b1;
        end else if (act_q == SUB_RECSPEED) begin
          // one EIOS, then hold electrical idle until the RX side finishes
          if (cnt_d != '0) begin
            valid_d = 1'b0;
            ei_d    = 1'b1;
            if (rx_nx) begin
              state_d = S_DONE;
              fin_d   = 1'b1;
            end
          end
        end else if (cnt_d >= sub_min(act_q) && rx_nx) begin
          if (sub_post(act_q)) begin
            state_d = S_POST;
          end else begin
            state_d = S_DONE;
            valid_d = 1'b0;
            fin_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = act_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (!valid_d) begin
      type_d = OS_NONE;
      link_d = 8'h00;
    end
    mask_d = {MAXLANES{valid_d}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= 5'h1F;
      act_q   <= 5'h1F;
      rx_q    <= 1'b0;
      cnt_q   <= '0;
      post_q  <= '0;
      valid_q <= 1'b0;
      type_q  <= OS_NONE;
      link_q  <= 8'h00;
      mask_q  <= '0;
      ei_q    <= 1'b1;
      de_q    <= 1'b0;
      fin_q   <= 1'b0;
`ifdef EIEOS_INSERT_EN
      ts_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      act_q   <= act_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      post_q  <= post_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      link_q  <= link_d;
      mask_q  <= mask_d;
      ei_q    <= ei_d;
      de_q    <= de_d;
      fin_q   <= fin_d;
`ifdef EIEOS_INSERT_EN
      ts_q    <= ts_d;
`endif
    end
  end

  assign osValid          = valid_q;
  assign osType           = type_q;
  assign osLinkNum        = link_q;
  assign osLaneMask       = mask_q;
  assign txElectricalIdle = ei_q;
  assign dataEnable       = de_q;
  assign txFinish         = fin_q;
  assign sentCount        = cnt_q;

endmodule

// File: tb/tb_master_tx_ltssm.sv
// Directed bench for master_tx_ltssm; inputs driven and outputs sampled on the falling edge.
module tb_master_tx_ltssm;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  substate;
  logic [2:0]  trainToGen;
  logic        rxFinish;
  logic [7:0]  linkNumber;
  logic        osReady;
  logic        osValid;
  logic [2:0]  osType;
  logic [7:0]  osLinkNum;
  logic [15:0] osLaneMask;
  logic        txElectricalIdle, dataEnable, txFinish;
  logic [10:0] sentCount;

  int n_chk  = 0;
  int n_pass = 0;

  master_tx_ltssm dut (
    .clk(clk), .reset(reset), .substate(substate), .trainToGen(trainToGen),
    .rxFinish(rxFinish), .linkNumber(linkNumber), .osReady(osReady),
    .osValid(osValid), .osType(osType), .osLinkNum(osLinkNum), .osLaneMask(osLaneMask),
    .txElectricalIdle(txElectricalIdle), .dataEnable(dataEnable), .txFinish(txFinish),
    .sentCount(sentCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Run one substate to its txFinish; rx pulses at cycle rx_cyc, tgl alternates osReady.
  task automatic run_os(input logic [4:0] sub, input logic [2:0] ety, input logic [7:0] elink,
                        input int rx_cyc, input bit tgl, input int eacc, input string tag);
    int acc = 0, fins = 0, sc = 0;
    bit done = 0, stall_bad = 0, ty_bad = 0, link_bad = 0, mask_bad = 0;
    bit pv = 0;
    logic [2:0] pt = 3'd0;
    substate = sub;
    for (int c = 1; c <= 3000 && !done; c++) begin
      @(negedge clk);
      if (txFinish) begin
        fins++; sc = sentCount; done = 1;
      end else begin
        if (pv && !(osValid && osType == pt)) stall_bad = 1;
        if (osValid && osType != ety)   ty_bad   = 1;
        if (osValid && osLinkNum != elink) link_bad = 1;
        if (osLaneMask != {16{osValid}}) mask_bad = 1;
        osReady  = tgl ? c[0] : 1'b1;
        rxFinish = (c == rx_cyc);
        if (osValid && osReady) acc++;
        pv = osValid && !osReady;
        pt = osType;
      end
    end
    osReady = 1'b0; rxFinish = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (txFinish) fins++;
    end
    chk({tag, "_fin"},    fins, 1);
    chk({tag, "_acc"},    acc, eacc);
    chk({tag, "_cnt"},    sc, eacc);
    chk({tag, "_stall"},  stall_bad, 0);
    chk({tag, "_type"},   ty_bad, 0);
    chk({tag, "_link"},   link_bad, 0);
    chk({tag, "_mask"},   mask_bad, 0);
  endtask

  initial begin
    bit bad;
    reset = 1'b0; substate = 5'd2; trainToGen = 3'd2; rxFinish = 1'b0;
    linkNumber = 8'h2A; osReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", osValid, 0);
    chk("rst_type",  osType, 0);
    chk("rst_link",  osLinkNum, 0);
    chk("rst_mask",  osLaneMask, 0);
    chk("rst_ei",    txElectricalIdle, 1);
    chk("rst_de",    dataEnable, 0);
    chk("rst_fin",   txFinish, 0);
    chk("rst_cnt",   sentCount, 0);

    // enter pollingActive with the datapath stalled, then reset mid-SEND
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("send_valid", osValid, 1);
    chk("send_mask",  osLaneMask, 16'hFFFF);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", osValid, 0);
    chk("async_ei",    txElectricalIdle, 1);
    chk("async_fin",   txFinish, 0);
    substate = 5'd0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) chk("det_fin_c1", txFinish, 0);
    @(negedge clk) begin
      chk("det_fin_c2", txFinish, 1);
      chk("det_ei",     txElectricalIdle, 1);
    end
    @(negedge clk) chk("det_fin_c3", txFinish, 0);

    run_os(5'd2, 3'd1, 8'hF7, 100, 1'b0, 1024, "polla");
    run_os(5'd3, 3'd2, 8'hF7, 5,   1'b0, 21,   "pcfg");
    run_os(5'd8, 3'd2, 8'h2A, 3,   1'b1, 18,   "cfgc");

    // abort cfgLinkWidthStart after 3 TS1
    substate = 5'd4; osReady = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk) begin
      chk("abort_cnt3", sentCount, 3);
      substate = 5'd5; osReady = 1'b0;
    end
    @(negedge clk) begin
      chk("abort_valid", osValid, 0);
      chk("abort_fin",   txFinish, 0);
    end
    @(negedge clk) begin
      chk("restart_valid", osValid, 1);
      chk("restart_type",  osType, 1);
      chk("restart_cnt",   sentCount, 0);
      chk("restart_fin",   txFinish, 0);
    end
    run_os(5'd5, 3'd1, 8'h2A, 2, 1'b0, 2, "cfga");

    // same substate must not restart
    bad = 0;
    osReady = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (osValid || txFinish) bad = 1;
    end
    osReady = 1'b0;
    chk("reentry_idle", bad, 0);

    // L0: data path on, never finishes
    substate = 5'd10;
    @(negedge clk);
    @(negedge clk) begin
      chk("l0_de",    dataEnable, 1);
      chk("l0_ei",    txElectricalIdle, 0);
      chk("l0_valid", osValid, 0);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (txFinish || osValid) bad = 1;
      rxFinish = (i == 2);
      osReady  = 1'b1;
    end
    rxFinish = 1'b0; osReady = 1'b0;
    chk("l0_nofin", bad, 0);

    run_os(5'd13, 3'd4, 8'h2A, 4, 1'b0, 1, "rspd");
    chk("rspd_ei", txElectricalIdle, 1);
    chk("rspd_de", dataEnable, 0);

    run_os(5'd18, 3'd3, 8'h2A, 1, 1'b0, 17, "ridl");

`ifdef EIEOS_INSERT_EN
    trainToGen = 3'd3; substate = 5'd11; osReady = 1'b1;
    @(negedge clk) chk("eieos_first", osType, 5);
    bad = 0;
    repeat (32) begin
      @(negedge clk);
      if (osType != 3'd1) bad = 1;
    end
    chk("eieos_ts1_run", bad, 0);
    @(negedge clk) begin
      chk("eieos_second", osType, 5);
      chk("eieos_cnt",    sentCount, 32);
    end
    osReady = 1'b0; trainToGen = 3'd2;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/master_tx_ltssm.md
Name: master_tx_ltssm

Overview:
- Transmit-side companion of the master receive LTSSM sequencer.
- For each LTSSM substate from the main LTSSM, drives the lane TX datapath with the ordered-set stream that substate requires: TS1, TS2, IDLE, EIOS or electrical idle.
- Counts accepted ordered sets and combines the count with the receive side's finish pulse.
- Pulses txFinish when the transmit obligations of the substate are met. The main LTSSM ANDs txFinish with the RX finish before advancing.

Parameters:
- MAXLANES, 16, lane count supported; sizes no logic here beyond documentation of osLaneMask.
- POLL_MIN, 1024, minimum TS1 count in pollingActive.
- POST_COUNT, 16, ordered sets sent after rxFinish in TS2/IDLE substates.
- CNT_W, 11, width of the sent-OS counter; must satisfy 2^CNT_W > POLL_MIN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- substate  in  5  current LTSSM substate. Encoding: detectQuiet=0, detectActive=1, pollingActive=2, pollingConfiguration=3, cfgLinkWidthStart=4, cfgLinkWidthAccept=5, cfgLanenumWait=6, cfgLanenumAccept=7, cfgComplete=8, cfgIdle=9, L0=10, recRcvrLock=11, recRcvrCfg=12, recSpeed=13, phase0..3=14..17, recIdle=18.
- trainToGen  in  3  target generation; 3 = Gen3.
- rxFinish  in  1  one-cycle finish pulse from the RX LTSSM.
- linkNumber  in  8  link number inserted in TS; PAD (8'hF7) in pollingActive, pollingConfiguration and cfgLinkWidthStart.
- osReady  in  1  TX datapath accepts the presented ordered set.
- osValid  out  1  ordered-set request.
- osType  out  3  0 NONE, 1 TS1, 2 TS2, 3 IDLE, 4 EIOS, 5 EIEOS.
- osLinkNum  out  8  link field for TS.
- osLaneMask  out  MAXLANES  all ones while osValid; zero otherwise.
- txElectricalIdle  out  1  drive lanes to electrical idle.
- dataEnable  out  1  L0 data path enabled.
- txFinish  out  1  one-cycle completion pulse.
- sentCount  out  CNT_W  ordered sets accepted in the current substate; saturates at all-ones.

Behaviour:
- Reset values:
  - FSM state IDLE; lastState=5'h1F; rxSeen=0; sentCount=0.
  - osValid=0, osType=0, osLinkNum=0, osLaneMask=0.
  - txElectricalIdle=1, dataEnable=0, txFinish=0.
- FSM states are IDLE, SEND, POST, DONE.
- IDLE:
  - If substate != lastState, latch actSub=substate, clear sentCount and rxSeen, then go to SEND next cycle.
  - Otherwise remain in IDLE with osValid=0.
- Per-substate table (osType / min count / post count):
  - detectQuiet, detectActive: none. txElectricalIdle=1; go to DONE directly.
  - pollingActive: TS1 / POLL_MIN / 0.
  - pollingConfiguration, cfgComplete, recRcvrCfg: TS2 / 1 / POST_COUNT.
  - cfgLinkWidthStart/Accept, cfgLanenumWait/Accept, recRcvrLock, phase0..3: TS1 / 1 / 0.
  - cfgIdle, recIdle: IDLE / 1 / POST_COUNT.
  - recSpeed: one EIOS, then txElectricalIdle=1 with osValid=0 until rxSeen; then DONE.
  - L0: dataEnable=1, osValid=0, txElectricalIdle=0. Never finishes; leaves only on a substate change.
- SEND:
  - osValid=1 with the table osType.
  - On every osValid && osReady cycle, sentCount increments, saturating.
  - osValid and osType stay stable until accepted.
- rxSeen:
  - Set by rxFinish in any state except IDLE; remains set until the next IDLE entry.
  - rxFinish and the final osReady in the same cycle both count.
- SEND exit: when sentCount >= min and rxSeen, go to POST if post count > 0, else DONE.
- POST: send post-count further ordered sets of the same type, counted by a separate counter; then DONE.
- DONE: txFinish=1 for exactly one cycle; lastState <= actSub; return to IDLE.
- Abort: if substate != actSub in SEND or POST, the next cycle has osValid=0 and the FSM is in IDLE.
  - No txFinish is issued.
  - lastState is unchanged, so the new substate starts immediately.
  - An ordered set accepted in the abort cycle is counted, but the count is then discarded.
- Re-entry: the same substate is not restarted until substate differs from lastState.

Optional Feature:
- Macro: EIEOS_INSERT_EN.
- When defined and trainToGen==3:
  - One EIEOS is sent before the first TS1 of recRcvrLock.
  - One EIEOS is inserted after every 32 accepted TS1/TS2.
  - EIEOS is not counted in sentCount.
- When not defined: osType never equals 5, and behaviour matches the table exactly.

Test Plan:
- Reset asserted mid-SEND -> within the same cycle osValid=0, txElectricalIdle=1, txFinish=0; after release, substate=0 -> txFinish pulse 2 cycles later.
- substate=2, osReady=1 constantly, rxFinish at cycle 100 -> exactly 1024 TS1 accepted, then one txFinish; sentCount=1024.
- substate=3, rxFinish after 5 TS2 -> 16 further TS2 accepted (21 total), then txFinish; osLinkNum=8'hF7.
- substate=8 with osReady toggling 1/0 -> osType and osValid stable while stalled; txFinish after rxSeen plus 16 accepted TS2.
- substate changes 4->5 after 3 TS1 with no rxFinish -> no txFinish; one cycle later TS1 restarts with sentCount=0.
- With EIEOS_INSERT_EN defined, trainToGen=3, substate=11 -> first osType=5, then 32 TS1, then another EIEOS.
